// File: rtl/game_sequencer_if.sv
// ---------------------------------------------------------------------------
// game_sequencer_if
// Purpose : groups the signals exchanged between the game sequencer and the
//           ball / collision controllers of the breakout design.
// Signals :
//   lose       ball passed the paddle (level, from ball logic)
//   win        all bricks cleared (level, from collision logic)
//   block_hit  one-cycle pulse per destroyed brick (from collision logic)
//   ball_start one-cycle pulse that launches the ball (to ball logic)
//   ball_hold  ball parked on the paddle, movement frozen (to ball logic)
//   blk_reload one-cycle pulse restoring all bricks (to collision logic)
// Modports:
//   master  the game sequencer side
//   slave   the ball / collision controller side
// ---------------------------------------------------------------------------
interface game_sequencer_if;
  logic lose;
  logic win;
  logic block_hit;
  logic ball_start;
  logic ball_hold;
  logic blk_reload;

  modport master (
    input  lose,
    input  win,
    input  block_hit,
    output ball_start,
    output ball_hold,
    output blk_reload
  );

  modport slave (
    output lose,
    output win,
    output block_hit,
    input  ball_start,
    input  ball_hold,
    input  blk_reload
  );
endinterface

// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
// Purpose : top-level game-flow controller for breakout. Sequences rounds
//           (idle, serve, play, life lost, level clear, game over / won),
//           gates the ball controller, tracks lives, score and level and
//           requests brick-wall reloads. All outputs are registered.
// Ports   :
//   i_pxl_clk    pixel clock, the only clock
//   i_reset      synchronous active-high reset
//   i_vsync      VGA vsync; its rising edge is the frame tick
//   i_btn_start  start button (level)
//   bus          ball / collision handshake (master side)
//   o_lives      remaining lives
//   o_score      accumulated score (saturating)
//   o_level      current level, 0-based
//   o_state      IDLE=0 SERVE=1 PLAY=2 MISS=3 CLEAR=4 OVER=5 WON=6
//   o_game_over  high in OVER or WON
// ---------------------------------------------------------------------------
module game_sequencer #(
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned MISS_FRAMES  = 60,
  parameter int unsigned CLEAR_FRAMES = 120,
  parameter int unsigned MAX_LEVEL    = 3,
  parameter int unsigned SCORE_W      = 12
) (
  input  logic               i_pxl_clk,
  input  logic               i_reset,
  input  logic               i_vsync,
  input  logic               i_btn_start,
  game_sequencer_if.master   bus,
  output logic [1:0]         o_lives,
  output logic [SCORE_W-1:0] o_score,
  output logic [1:0]         o_level,
  output logic [2:0]         o_state,
  output logic               o_game_over
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_MISS  = 3'd3,
    S_CLEAR = 3'd4,
    S_OVER  = 3'd5,
    S_WON   = 3'd6
  } state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX   = {SCORE_W{1'b1}};
  localparam logic [7:0]         MISS_LAST   = 8'(MISS_FRAMES - 1);
  localparam logic [7:0]         CLEAR_LAST  = 8'(CLEAR_FRAMES - 1);
  localparam logic [1:0]         LEVEL_LAST  = 2'(MAX_LEVEL - 1);
  localparam logic [1:0]         LIVES_START = 2'(LIVES_INIT);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_btn_q;
  logic                 r_vsync_q;
  logic [7:0]           r_frame_cnt;
  logic [7:0]           w_frame_cnt_nxt;
  logic [1:0]           r_lives;
  logic [1:0]           w_lives_nxt;
  logic [SCORE_W-1:0]   r_score;
  logic [SCORE_W-1:0]   w_score_nxt;
  logic [1:0]           r_level;
  logic [1:0]           w_level_nxt;
  logic                 r_ball_start;
  logic                 w_ball_start_nxt;
  logic                 r_ball_hold;
  logic                 w_ball_hold_nxt;
  logic                 r_blk_reload;
  logic                 w_blk_reload_nxt;
  logic                 r_game_over;
  logic                 w_game_over_nxt;

  logic                 w_start_edge;
  logic                 w_frame_tick;
  logic                 w_miss_done;
  logic                 w_clear_done;
  logic [SCORE_W:0]     w_score_sum;

  assign w_start_edge = i_btn_start & ~r_btn_q;
  assign w_frame_tick = i_vsync & ~r_vsync_q;
  // The exit fires on the tick that would take the counter past its last value.
  assign w_miss_done  = w_frame_tick && (r_frame_cnt == MISS_LAST);
  assign w_clear_done = w_frame_tick && (r_frame_cnt == CLEAR_LAST);
  // One extra bit catches the carry used for saturation; a hit is worth level+1.
  assign w_score_sum  = {1'b0, r_score} + {{(SCORE_W-1){1'b0}}, r_level}
                        + {{SCORE_W{1'b0}}, 1'b1};

  // Next-state, counters and registered-output values for the game flow.
  always_comb begin
    w_state_nxt      = r_state;
    w_lives_nxt      = r_lives;
    w_score_nxt      = r_score;
    w_level_nxt      = r_level;
    w_ball_start_nxt = 1'b0;
    w_blk_reload_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_state_nxt      = S_SERVE;
          w_lives_nxt      = LIVES_START;
          w_score_nxt      = {SCORE_W{1'b0}};
          w_level_nxt      = 2'd0;
          w_blk_reload_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SERVE: begin
        if (w_start_edge) begin
          w_state_nxt      = S_PLAY;
          w_ball_start_nxt = 1'b1;
        end else begin
          w_state_nxt = S_SERVE;
        end
      end
      S_PLAY: begin
        // Hits are scored even in the cycle that ends play.
        if (bus.block_hit) begin
          w_score_nxt = w_score_sum[SCORE_W] ? SCORE_MAX : w_score_sum[SCORE_W-1:0];
        end else begin
          w_score_nxt = r_score;
        end
        if (bus.win) begin
          w_state_nxt = S_CLEAR;
        end else if (bus.lose) begin
          if (r_lives != 2'd0) begin
            w_lives_nxt = r_lives - 2'd1;
          end else begin
            w_lives_nxt = r_lives;
          end
          w_state_nxt = (r_lives == 2'd1) ? S_OVER : S_MISS;
        end else begin
          w_state_nxt = S_PLAY;
        end
      end
      S_MISS: begin
        if (w_miss_done) begin
          w_state_nxt = S_SERVE;
        end else begin
          w_state_nxt = S_MISS;
        end
      end
      S_CLEAR: begin
        if (w_clear_done) begin
          if (r_level == LEVEL_LAST) begin
            w_state_nxt = S_WON;
          end else begin
            w_state_nxt      = S_SERVE;
            w_level_nxt      = r_level + 2'd1;
            w_blk_reload_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_OVER, S_WON: begin
        if (w_start_edge) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Counter restarts on every state change so each timed state starts at zero.
    if (w_state_nxt != r_state) begin
      w_frame_cnt_nxt = 8'd0;
    end else if (w_frame_tick && ((r_state == S_MISS) || (r_state == S_CLEAR))) begin
      w_frame_cnt_nxt = r_frame_cnt + 8'd1;
    end else begin
      w_frame_cnt_nxt = r_frame_cnt;
    end

    w_ball_hold_nxt = (w_state_nxt != S_PLAY);
    w_game_over_nxt = (w_state_nxt == S_OVER) || (w_state_nxt == S_WON);
  end

  // State, edge-detect and output registers with synchronous reset.
  always_ff @(posedge i_pxl_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_btn_q      <= 1'b0;
      r_vsync_q    <= 1'b0;
      r_frame_cnt  <= 8'd0;
      r_lives      <= 2'd0;
      r_score      <= {SCORE_W{1'b0}};
      r_level      <= 2'd0;
      r_ball_start <= 1'b0;
      r_ball_hold  <= 1'b1;
      r_blk_reload <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_btn_q      <= i_btn_start;
      r_vsync_q    <= i_vsync;
      r_frame_cnt  <= w_frame_cnt_nxt;
      r_lives      <= w_lives_nxt;
      r_score      <= w_score_nxt;
      r_level      <= w_level_nxt;
      r_ball_start <= w_ball_start_nxt;
      r_ball_hold  <= w_ball_hold_nxt;
      r_blk_reload <= w_blk_reload_nxt;
      r_game_over  <= w_game_over_nxt;
    end
  end

  assign bus.ball_start = r_ball_start;
  assign bus.ball_hold  = r_ball_hold;
  assign bus.blk_reload = r_blk_reload;
  assign o_lives        = r_lives;
  assign o_score        = r_score;
  assign o_level        = r_level;
  assign o_state        = r_state;
  assign o_game_over    = r_game_over;

endmodule

// File: tb/tb_game_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_sequencer
// Purpose : self-checking bench for game_sequencer. Each task drives one
//           scenario; expected output snapshots, built from a small model of
//           the game flow, are queued as stimulus is applied and compared
//           against the outputs observed one clock later.
// ---------------------------------------------------------------------------
module tb_game_sequencer;

  typedef struct packed {
    logic [2:0]  st;
    logic [1:0]  lv;
    logic [11:0] sc;
    logic [1:0]  lev;
    logic        hold;
    logic        start;
    logic        reload;
    logic        go;
  } snap_t;

  logic        clk;
  logic        reset;
  logic        vsync;
  logic        btn;
  logic [1:0]  lives;
  logic [11:0] score;
  logic [1:0]  level;
  logic [2:0]  state;
  logic        game_over;

  game_sequencer_if bus ();

  game_sequencer dut (
    .i_pxl_clk   (clk),
    .i_reset     (reset),
    .i_vsync     (vsync),
    .i_btn_start (btn),
    .bus         (bus),
    .o_lives     (lives),
    .o_score     (score),
    .o_level     (level),
    .o_state     (state),
    .o_game_over (game_over)
  );

  // Pixel clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  snap_t sb[$];
  snap_t obs[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  // Model of the expected game status.
  int m_state = 0;
  int m_lives = 0;
  int m_score = 0;
  int m_level = 0;

  function automatic snap_t exp_now(input logic p_start, input logic p_reload);
    snap_t e;
    e.st     = 3'(m_state);
    e.lv     = 2'(m_lives);
    e.sc     = 12'(m_score);
    e.lev    = 2'(m_level);
    e.hold   = (m_state != 2);
    e.start  = p_start;
    e.reload = p_reload;
    e.go     = (m_state == 5) || (m_state == 6);
    return e;
  endfunction

  function automatic snap_t snap();
    snap_t o;
    o = {state, lives, score, level, bus.ball_hold, bus.ball_start, bus.blk_reload, game_over};
    return o;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Queue the expectation, let one clock pass, record what the DUT shows.
  task automatic step(input logic p_start, input logic p_reload);
    sb.push_back(exp_now(p_start, p_reload));
    tick();
    obs.push_back(snap());
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1; tick();
      vsync = 1'b0; tick();
    end
  endtask

  task automatic press_to_play();
    btn = 1'b1; m_state = 2; step(1'b1, 1'b0);
    btn = 1'b0; step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    snap_t e, o;
    reset = 1'b1; vsync = 1'b0; btn = 1'b0;
    bus.lose = 1'b0; bus.win = 1'b0; bus.block_hit = 1'b0;
    tick(); tick();
    m_state = 0; m_lives = 0; m_score = 0; m_level = 0;
    step(1'b0, 1'b0);
    reset = 1'b0;
    step(1'b0, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL reset[%0d] got st=%0d lv=%0d sc=%0d lev=%0d h=%b s=%b r=%b go=%b want st=%0d lv=%0d sc=%0d lev=%0d h=%b s=%b r=%b go=%b",
                 i, o.st, o.lv, o.sc, o.lev, o.hold, o.start, o.reload, o.go,
                 e.st, e.lv, e.sc, e.lev, e.hold, e.start, e.reload, e.go);
      end
    end
  endtask

  task automatic test_start_serve();
    snap_t e, o;
    btn = 1'b1; m_state = 1; m_lives = 3; m_score = 0; m_level = 0;
    step(1'b0, 1'b1);
    btn = 1'b0; step(1'b0, 1'b0);
    press_to_play();
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL start_serve[%0d] got st=%0d lv=%0d sc=%0d lev=%0d h=%b s=%b r=%b go=%b want st=%0d lv=%0d sc=%0d lev=%0d h=%b s=%b r=%b go=%b",
                 i, o.st, o.lv, o.sc, o.lev, o.hold, o.start, o.reload, o.go,
                 e.st, e.lv, e.sc, e.lev, e.hold, e.start, e.reload, e.go);
      end
    end
  endtask

  task automatic test_lose_miss();
    snap_t e, o;
    // Three level-0 hits, one point each.
    for (int k = 0; k < 3; k++) begin
      bus.block_hit = 1'b1; m_score = m_score + 1; step(1'b0, 1'b0);
      bus.block_hit = 1'b0; step(1'b0, 1'b0);
    end
    bus.lose = 1'b1; m_state = 3; m_lives = 2; step(1'b0, 1'b0);
    bus.lose = 1'b0;
    // Hits, win and start are all ignored in MISS.
    bus.block_hit = 1'b1; bus.win = 1'b1; step(1'b0, 1'b0);
    bus.block_hit = 1'b0; bus.win = 1'b0;
    btn = 1'b1; step(1'b0, 1'b0);
    btn = 1'b0;
    frames(59);
    step(1'b0, 1'b0);
    vsync = 1'b1; m_state = 1; step(1'b0, 1'b0);
    vsync = 1'b0; step(1'b0, 1'b0);
    press_to_play();
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL lose_miss[%0d] got st=%0d lv=%0d sc=%0d lev=%0d h=%b s=%b r=%b go=%b want st=%0d lv=%0d sc=%0d lev=%0d h=%b s=%b r=%b go=%b",
                 i, o.st, o.lv, o.sc, o.lev, o.hold, o.start, o.reload, o.go,
                 e.st, e.lv, e.sc, e.lev, e.hold, e.start, e.reload, e.go);
      end
    end
  endtask

  task automatic test_win_clear();
    snap_t e, o;
    // win beats lose; the simultaneous hit still scores.
    bus.win = 1'b1; bus.lose = 1'b1; bus.block_hit = 1'b1;
    m_state = 4; m_score = m_score + 1; step(1'b0, 1'b0);
    bus.win = 1'b0; bus.lose = 1'b0; bus.block_hit = 1'b0;
    frames(119);
    step(1'b0, 1'b0);
    vsync = 1'b1; m_state = 1; m_level = 1; step(1'b0, 1'b1);
    vsync = 1'b0; step(1'b0, 1'b0);
    press_to_play();
    for (int k = 0; k < 5; k++) begin
      bus.block_hit = 1'b1; m_score = m_score + 2; step(1'b0, 1'b0);
      bus.block_hit = 1'b0; step(1'b0, 1'b0);
    end
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL win_clear[%0d] got st=%0d lv=%0d sc=%0d lev=%0d h=%b s=%b r=%b go=%b want st=%0d lv=%0d sc=%0d lev=%0d h=%b s=%b r=%b go=%b",
                 i, o.st, o.lv, o.sc, o.lev, o.hold, o.start, o.reload, o.go,
                 e.st, e.lv, e.sc, e.lev, e.hold, e.start, e.reload, e.go);
      end
    end
  endtask

  task automatic test_saturate();
    snap_t e, o;
    int n;
    // Level 1: each cycle of held block_hit adds 2; climb to 4094.
    n = (4094 - m_score) / 2;
    bus.block_hit = 1'b1;
    repeat (n) tick();
    bus.block_hit = 1'b0;
    m_score = m_score + 2 * n;
    step(1'b0, 1'b0);
    bus.block_hit = 1'b1; m_score = 4095; step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    bus.block_hit = 1'b0; step(1'b0, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL saturate[%0d] got st=%0d lv=%0d sc=%0d lev=%0d h=%b s=%b r=%b go=%b want st=%0d lv=%0d sc=%0d lev=%0d h=%b s=%b r=%b go=%b",
                 i, o.st, o.lv, o.sc, o.lev, o.hold, o.start, o.reload, o.go,
                 e.st, e.lv, e.sc, e.lev, e.hold, e.start, e.reload, e.go);
      end
    end
  endtask

  task automatic test_level_won();
    snap_t e, o;
    bus.win = 1'b1; m_state = 4; step(1'b0, 1'b0);
    bus.win = 1'b0;
    frames(119);
    vsync = 1'b1; m_state = 1; m_level = 2; step(1'b0, 1'b1);
    vsync = 1'b0; step(1'b0, 1'b0);
    press_to_play();
    bus.win = 1'b1; m_state = 4; step(1'b0, 1'b0);
    bus.win = 1'b0;
    frames(119);
    step(1'b0, 1'b0);
    // Last level: no reload, level stays, game over.
    vsync = 1'b1; m_state = 6; step(1'b0, 1'b0);
    vsync = 1'b0; step(1'b0, 1'b0);
    btn = 1'b1; m_state = 0; step(1'b0, 1'b0);
    btn = 1'b0; step(1'b0, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL level_won[%0d] got st=%0d lv=%0d sc=%0d lev=%0d h=%b s=%b r=%b go=%b want st=%0d lv=%0d sc=%0d lev=%0d h=%b s=%b r=%b go=%b",
                 i, o.st, o.lv, o.sc, o.lev, o.hold, o.start, o.reload, o.go,
                 e.st, e.lv, e.sc, e.lev, e.hold, e.start, e.reload, e.go);
      end
    end
  endtask

  task automatic test_held_button();
    snap_t e, o;
    btn = 1'b1; m_state = 1; m_lives = 3; m_score = 0; m_level = 0;
    step(1'b0, 1'b1);
    repeat (998) tick();
    step(1'b0, 1'b0);
    btn = 1'b0; step(1'b0, 1'b0);
    press_to_play();
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL held_button[%0d] got st=%0d lv=%0d sc=%0d lev=%0d h=%b s=%b r=%b go=%b want st=%0d lv=%0d sc=%0d lev=%0d h=%b s=%b r=%b go=%b",
                 i, o.st, o.lv, o.sc, o.lev, o.hold, o.start, o.reload, o.go,
                 e.st, e.lv, e.sc, e.lev, e.hold, e.start, e.reload, e.go);
      end
    end
  endtask

  task automatic test_game_over();
    snap_t e, o;
    for (int k = 0; k < 2; k++) begin
      bus.lose = 1'b1; m_state = 3; m_lives = m_lives - 1; step(1'b0, 1'b0);
      bus.lose = 1'b0;
      frames(59);
      vsync = 1'b1; m_state = 1; step(1'b0, 1'b0);
      vsync = 1'b0; step(1'b0, 1'b0);
      press_to_play();
    end
    bus.lose = 1'b1; m_state = 5; m_lives = 0; step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    bus.lose = 1'b0;
    btn = 1'b1; m_state = 0; step(1'b0, 1'b0);
    btn = 1'b0; step(1'b0, 1'b0);
    bus.lose = 1'b1; step(1'b0, 1'b0);
    bus.lose = 1'b0;
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL game_over[%0d] got st=%0d lv=%0d sc=%0d lev=%0d h=%b s=%b r=%b go=%b want st=%0d lv=%0d sc=%0d lev=%0d h=%b s=%b r=%b go=%b",
                 i, o.st, o.lv, o.sc, o.lev, o.hold, o.start, o.reload, o.go,
                 e.st, e.lv, e.sc, e.lev, e.hold, e.start, e.reload, e.go);
      end
    end
  endtask

  task automatic test_reset_midgame();
    snap_t e, o;
    btn = 1'b1; m_state = 1; m_lives = 3; m_score = 0; m_level = 0;
    step(1'b0, 1'b1);
    btn = 1'b0; step(1'b0, 1'b0);
    press_to_play();
    bus.lose = 1'b1; m_state = 3; m_lives = 2; step(1'b0, 1'b0);
    bus.lose = 1'b0;
    frames(30);
    reset = 1'b1; m_state = 0; m_lives = 0; m_score = 0; m_level = 0;
    step(1'b0, 1'b0);
    reset = 1'b0;
    bus.lose = 1'b1; step(1'b0, 1'b0);
    bus.lose = 1'b0; step(1'b0, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obs.pop_front(); n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL reset_midgame[%0d] got st=%0d lv=%0d sc=%0d lev=%0d h=%b s=%b r=%b go=%b want st=%0d lv=%0d sc=%0d lev=%0d h=%b s=%b r=%b go=%b",
                 i, o.st, o.lv, o.sc, o.lev, o.hold, o.start, o.reload, o.go,
                 e.st, e.lv, e.sc, e.lev, e.hold, e.start, e.reload, e.go);
      end
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_start_serve();
    test_lose_miss();
    test_win_clear();
    test_saturate();
    test_level_won();
    test_held_button();
    test_game_over();
    test_reset_midgame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-flow controller for the breakout design.
- Sequences rounds: idle/attract, serve, play, life lost, level clear, game over/won.
- Gates the ball controller (serve pulse, hold), tracks lives, score and level, and requests brick-wall reloads from the collision controller.
- Inputs come from the ball/collision logic and the buttons; the frame cadence comes from the VGA timing generator's vsync.

Parameters:
- LIVES_INIT, 3, lives loaded at game start (1..3).
- MISS_FRAMES, 60, frames spent in MISS before re-serve (1..255).
- CLEAR_FRAMES, 120, frames spent in CLEAR before the next level (1..255).
- MAX_LEVEL, 3, number of levels (1..4).
- SCORE_W, 12, score width in bits.

Ports:
- pxl_clk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- vsync  in  1  VGA vertical sync; frame tick = rising edge sampled on pxl_clk.
- btn_start  in  1  start button, level.
- lose  in  1  level; ball passed the paddle.
- win  in  1  level; all bricks cleared.
- block_hit  in  1  one-cycle pulse per brick destroyed.
- ball_start  out  1  one-cycle pulse; launches the ball.
- ball_hold  out  1  ball parked on the paddle, movement frozen.
- blk_reload  out  1  one-cycle pulse; restore all brick status bits.
- lives  out  2  remaining lives.
- score  out  SCORE_W  accumulated score.
- level  out  2  current level, 0-based.
- state  out  3  IDLE=0, SERVE=1, PLAY=2, MISS=3, CLEAR=4, OVER=5, WON=6.
- game_over  out  1  high in OVER or WON.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, ball_hold=1, ball_start=0, blk_reload=0, lives=0, score=0, level=0, game_over=0; frame counter=0, edge registers=0.
- Reset asserted mid-game returns everything to these values on the next edge, overriding any transition in progress.
- start_edge = btn_start & ~btn_start_q. frame_tick = vsync & ~vsync_q. Both are one cycle wide.
- Frame counter: 8 bits, cleared on every state change, increments on frame_tick only in MISS and CLEAR.
- ball_hold=1 in every state except PLAY.
- IDLE: on start_edge go to SERVE. Same edge: lives<=LIVES_INIT, score<=0, level<=0, blk_reload=1 for one cycle.
- SERVE: on start_edge go to PLAY with ball_start=1 for that one cycle. ball_hold drops on the same edge.
- PLAY, priority order:
  - win=1 goes to CLEAR. If win and lose are high in the same cycle, win wins and lives is unchanged.
  - else lose=1: lives<=lives-1, then OVER if lives==1, else MISS.
  - start_edge is ignored in PLAY.
- Scoring: block_hit adds (level+1) to score in PLAY only, saturating at 2^SCORE_W-1.
- A block_hit in the same cycle as win or lose is still counted.
- block_hit outside PLAY is ignored.
- MISS: when the counter reaches MISS_FRAMES-1 and frame_tick is high, go to SERVE. No brick reload.
- CLEAR: same exit condition using CLEAR_FRAMES.
  - If level==MAX_LEVEL-1, go to WON; level is unchanged.
  - Otherwise level<=level+1, blk_reload pulses, go to SERVE.
- OVER/WON: game_over=1; score, level and lives are held. start_edge goes to IDLE.
- A held btn_start produces only one edge; advancing requires release and re-press.
- The lose/win levels are sampled only in PLAY. Their persistence in other states has no effect.
- lives never underflows: the decrement only happens from a nonzero value in PLAY.
- Output latency: every output changes exactly one pxl_clk after the qualifying input edge is sampled.

Test Plan:
- Reset, then one btn_start press -> state=1, lives=3, score=0, level=0, blk_reload high exactly 1 cycle. A second press -> state=2, ball_start high 1 cycle, ball_hold=0.
- In PLAY at level=1, 5 block_hit pulses -> score=10. With score=4094 at level 1, one hit -> score=4095 (saturated).
- In PLAY, lose pulse with lives=3 -> state=3, lives=2. After exactly 60 vsync rising edges -> state=1. Repeat until lives=1, then lose -> state=5, lives=0, game_over=1.
- win and lose asserted in the same cycle with lives=2 -> state=4, lives=2. After 120 frames -> level=1, blk_reload pulse, state=1. The same sequence at level=2 -> state=6, game_over=1, level=2.
- btn_start held high for 1000 cycles from IDLE -> state advances only to 1. In OVER, a press returns to state=0.
- Reset asserted in MISS with the frame counter at 30 -> next cycle all outputs at reset values. A later lose in IDLE -> no change.
